// File: rtl/axi4_lite_dp_ram.sv
// AXI4-Lite slave RAM with independent write and read channel FSMs, byte strobes and SLVERR on out-of-range.
// Define RAM_RD_PIPE_EN to register the array output once more (2-cycle read latency).
module axi4_lite_dp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int RAM_DEPTH  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    aw_valid,
    output logic                    aw_ready,
    input  logic [ADDR_WIDTH-1:0]   aw_addr,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [DATA_WIDTH/8-1:0] w_strb,
    output logic                    b_valid,
    input  logic                    b_ready,
    output logic [1:0]              b_resp,
    input  logic                    ar_valid,
    output logic                    ar_ready,
    input  logic [ADDR_WIDTH-1:0]   ar_addr,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic [1:0]              r_resp
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int MEM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(RAM_DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_WDATA = 2'd1;
    localparam logic [1:0] W_WADDR = 2'd2;
    localparam logic [1:0] W_RESP  = 2'd3;

    localparam logic [1:0] R_IDLE  = 2'd0;
`ifdef RAM_RD_PIPE_EN
    localparam logic [1:0] R_PIPE  = 2'd1;
`endif
    localparam logic [1:0] R_RESP  = 2'd2;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> OFF_W) < DEPTH_A;
    endfunction

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic [1:0]            w_state;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  wr_commit;
    logic                  wr_ok;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [MEM_AW-1:0]     wr_idx;

    // Readies are gated by rst so every output is low while reset is held.
    assign aw_ready = !rst && (w_state == W_IDLE || w_state == W_WADDR);
    assign w_ready  = !rst && (w_state == W_IDLE || w_state == W_WDATA);
    assign b_valid  = (w_state == W_RESP);
    assign aw_hs    = aw_valid && aw_ready;
    assign w_hs     = w_valid && w_ready;

    // Commit uses whichever half arrives live on this edge and the captured copy of the other.
    always_comb begin
        wr_commit = 1'b0;
        wr_addr   = aw_addr;
        wr_data   = w_data;
        wr_strb   = w_strb;
        case (w_state)
            W_IDLE:  wr_commit = aw_hs && w_hs;
            W_WDATA: begin
                wr_commit = w_hs;
                wr_addr   = aw_addr_q;
            end
            W_WADDR: begin
                wr_commit = aw_hs;
                wr_data   = w_data_q;
                wr_strb   = w_strb_q;
            end
            default: ;
        endcase
    end

    assign wr_ok  = in_range(wr_addr);
    assign wr_idx = wr_addr[OFF_W +: MEM_AW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state   <= W_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_resp    <= RESP_OKAY;
        end else if (wr_commit) begin
            w_state <= W_RESP;
            b_resp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q <= aw_addr;
                        w_state   <= W_WDATA;
                    end else if (w_hs) begin
                        w_data_q <= w_data;
                        w_strb_q <= w_strb;
                        w_state  <= W_WADDR;
                    end
                end
                W_RESP: begin
                    if (b_ready) begin
                        w_state <= W_IDLE;
                        b_resp  <= RESP_OKAY;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the array has no reset so it survives rst and maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_commit && wr_ok) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    logic [1:0]            r_state;
    logic                  ar_hs;
    logic                  rd_ok;
    logic [MEM_AW-1:0]     rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;
`ifdef RAM_RD_PIPE_EN
    logic [DATA_WIDTH-1:0] pipe_data;
    logic                  pipe_err;
`endif

    assign ar_ready = !rst && (r_state == R_IDLE);
    assign r_valid  = (r_state == R_RESP);
    assign ar_hs    = ar_valid && ar_ready;
    assign rd_ok    = in_range(ar_addr);
    assign rd_idx   = ar_addr[OFF_W +: MEM_AW];
    assign rd_word  = rd_ok ? mem[rd_idx] : '0;

    // NOTE: the array write above is non-blocking, so a read sampled on the commit edge sees the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= R_IDLE;
            r_data    <= '0;
            r_resp    <= RESP_OKAY;
`ifdef RAM_RD_PIPE_EN
            pipe_data <= '0;
            pipe_err  <= 1'b0;
`endif
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
`ifdef RAM_RD_PIPE_EN
                        pipe_data <= rd_word;
                        pipe_err  <= !rd_ok;
                        r_state   <= R_PIPE;
`else
                        r_data    <= rd_word;
                        r_resp    <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        r_state   <= R_RESP;
`endif
                    end
                end
`ifdef RAM_RD_PIPE_EN
                R_PIPE: begin
                    r_data  <= pipe_data;
                    r_resp  <= pipe_err ? RESP_SLVERR : RESP_OKAY;
                    r_state <= R_RESP;
                end
`endif
                R_RESP: begin
                    if (r_ready) begin
                        r_state <= R_IDLE;
                        r_resp  <= RESP_OKAY;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_dp_ram.sv
// Directed bench for axi4_lite_dp_ram: vector table of single-cycle AW+W writes and reads,
// plus hand-written sequences for split AW/W, same-edge collision and mid-response reset.
module tb_axi4_lite_dp_ram;

    localparam int DW = 32;
    localparam int AW = 16;
`ifdef RAM_RD_PIPE_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          aw_valid = 1'b0;
    logic          aw_ready;
    logic [AW-1:0] aw_addr = '0;
    logic          w_valid = 1'b0;
    logic          w_ready;
    logic [DW-1:0] w_data = '0;
    logic [3:0]    w_strb = '0;
    logic          b_valid;
    logic          b_ready = 1'b0;
    logic [1:0]    b_resp;
    logic          ar_valid = 1'b0;
    logic          ar_ready;
    logic [AW-1:0] ar_addr = '0;
    logic          r_valid;
    logic          r_ready = 1'b0;
    logic [DW-1:0] r_data;
    logic [1:0]    r_resp;

    axi4_lite_dp_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(1024)) dut (
        .clk(clk), .rst(rst),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // All driving and sampling happens on the falling edge.
    task automatic wr_same(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic got);
        logic rdy = 1'b0;
        @(negedge clk);
        aw_addr = a; w_data = d; w_strb = s;
        aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (aw_ready && w_ready) begin rdy = 1'b1; break; end
            @(negedge clk);
        end
        if (!rdy) check("wr_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (b_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        resp = b_resp;
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp,
                      output int lat);
        logic rdy = 1'b0;
        @(negedge clk);
        ar_addr = a; ar_valid = 1'b1; r_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ar_ready) begin rdy = 1'b1; break; end
            @(negedge clk);
        end
        if (!rdy) check("rd_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        ar_valid = 1'b0;
        lat = 1;
        while (!r_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        d = r_data;
        resp = r_resp;
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
    endtask

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    strb;
        logic [1:0]    exp_resp;
        logic [DW-1:0] exp_data;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin
        logic [1:0]    resp;
        logic [DW-1:0] d;
        logic [DW-1:0] d0;
        logic          got;
        logic          stable;
        int            lat;
        int            extra;

        vecs[0]  = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 16'h0010, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 16'h4000, 32'h12345678, 4'hF, 2'b10, 32'h0};
        vecs[3]  = '{1'b0, 16'h4000, 32'h0,        4'h0, 2'b10, 32'h0};
        vecs[4]  = '{1'b1, 16'h0FFC, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0};
        vecs[5]  = '{1'b0, 16'h0FFC, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D};
        vecs[6]  = '{1'b1, 16'h0000, 32'h600DF00D, 4'hF, 2'b00, 32'h0};
        vecs[7]  = '{1'b1, 16'h1000, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
        vecs[8]  = '{1'b0, 16'h1000, 32'h0,        4'h0, 2'b10, 32'h0};
        vecs[9]  = '{1'b0, 16'h0000, 32'h0,        4'h0, 2'b00, 32'h600DF00D};
        vecs[10] = '{1'b1, 16'h0013, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0};
        vecs[11] = '{1'b0, 16'h0010, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        vecs[12] = '{1'b1, 16'h0012, 32'h55000000, 4'h8, 2'b00, 32'h0};
        vecs[13] = '{1'b0, 16'h0011, 32'h0,        4'h0, 2'b00, 32'h55ADBEEF};
        vecs[14] = '{1'b1, 16'h0040, 32'h12345678, 4'hF, 2'b00, 32'h0};
        vecs[15] = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
        vecs[16] = '{1'b1, 16'h0020, 32'hAAAAAAAA, 4'hF, 2'b00, 32'h0};

        // Reset held for 3 cycles: every output low, then readies high after release.
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {23'b0, aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp}, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", {aw_ready, w_ready, ar_ready, b_valid, r_valid}, 5'b11100);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) begin
                wr_same(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, got);
                check($sformatf("v%0d_bvalid", i), got, 1);
                check($sformatf("v%0d_bresp", i), resp, vecs[i].exp_resp);
            end else begin
                rd(vecs[i].addr, d, resp, lat);
                check($sformatf("v%0d_lat", i), lat, RD_LAT);
                check($sformatf("v%0d_rdata", i), d, vecs[i].exp_data);
                check($sformatf("v%0d_rresp", i), resp, vecs[i].exp_resp);
            end
        end

        // W first, AW three edges later: one response, only strobed bytes change.
        @(negedge clk);
        w_data = 32'h11223344; w_strb = 4'b0101; w_valid = 1'b1; b_ready = 1'b0;
        check("wfirst_w_ready", w_ready, 1);
        @(posedge clk);
        @(negedge clk);
        w_valid = 1'b0;
        check("wfirst_waddr_state", {aw_ready, w_ready, b_valid}, 3'b100);
        @(negedge clk);
        @(negedge clk);
        check("wfirst_no_early_b", b_valid, 0);
        aw_addr = 16'h0010; aw_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        aw_valid = 1'b0;
        check("wfirst_bvalid", b_valid, 1);
        check("wfirst_bresp", b_resp, 2'b00);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        extra = 0;
        repeat (3) begin
            if (b_valid) extra++;
            @(negedge clk);
        end
        check("wfirst_single_b", extra, 0);
        rd(16'h0010, d, resp, lat);
        check("wfirst_rdata", d, 32'hDE22BE44);

        // AW first, W two edges later.
        @(negedge clk);
        aw_addr = 16'h0030; aw_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        aw_valid = 1'b0;
        check("awfirst_wdata_state", {aw_ready, w_ready, b_valid}, 3'b010);
        @(negedge clk);
        w_data = 32'h0BADF00D; w_strb = 4'hF; w_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        w_valid = 1'b0;
        check("awfirst_bvalid", {b_valid, b_resp}, 3'b100);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        rd(16'h0030, d, resp, lat);
        check("awfirst_rdata", d, 32'h0BADF00D);

        // Write commit and read sample of the same word on one edge: read-first.
        @(negedge clk);
        aw_addr = 16'h0020; w_data = 32'h0; w_strb = 4'hF; aw_valid = 1'b1; w_valid = 1'b1;
        ar_addr = 16'h0020; ar_valid = 1'b1;
        check("collide_readies", {aw_ready, w_ready, ar_ready}, 3'b111);
        @(posedge clk);
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        lat = 1;
        while (!r_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("collide_lat", lat, RD_LAT);
        check("collide_rdata_old", r_data, 32'hAAAAAAAA);
        check("collide_bvalid", b_valid, 1);
        r_ready = 1'b1; b_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0; b_ready = 1'b0;
        rd(16'h0020, d, resp, lat);
        check("collide_rdata_new", d, 32'h0);

        // Stall in read response for 5 cycles, then reset mid-response.
        @(negedge clk);
        ar_addr = 16'h0040; ar_valid = 1'b1; r_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ar_valid = 1'b0;
        lat = 1;
        while (!r_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        d0 = r_data;
        check("stall_first_rdata", d0, 32'h12345678);
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!r_valid || r_data !== d0 || r_resp !== 2'b00) stable = 1'b0;
        end
        check("stall_stable", stable, 1);
        rst = 1'b1;
        #1;
        check("midreset_rvalid", r_valid, 0);
        check("midreset_outputs", {aw_ready, w_ready, ar_ready, b_valid, r_data, r_resp}, 38'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postreset2_state", {aw_ready, w_ready, ar_ready, r_valid, b_valid}, 5'b11100);
        rd(16'h0040, d, resp, lat);
        check("preserved_0x040", d, 32'h12345678);
        rd(16'h0010, d, resp, lat);
        check("preserved_0x010", d, 32'hDE22BE44);
        check("preserved_rresp", resp, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
